// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: operation encodings,
// default widths and the controller state type.
package shift_pkg;

    localparam int unsigned SHIFT_WIDTH = 16;
    localparam int unsigned SHIFT_AMT_W = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit step of a shift or rotate, purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Select one step of the requested operation; logical shifts fill with 0.
    always_comb begin
        dout = din;
        case (op_t'(op))
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: latches a job in IDLE, applies one 1-bit step per
// RUN cycle, then pulses done for a single cycle before returning to IDLE.
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_WIDTH,
    parameter int unsigned AMT_W = SHIFT_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    state_t           state;
    logic [1:0]       op_q;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_q),
        .din  (work),
        .dout (step_out)
    );

    assign dout = work;

    // Controller, step counter and working register; status flags are
    // registered alongside the state so they never depend on start directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            cnt   <= '0;
            work  <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        work  <= din;
                        cnt   <= amt;
                        ready <= 1'b0;
                        if (amt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work <= step_out;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: an acceptance model pushes expected
// results computed arithmetically; a monitor pops them on each done pulse.
module tb_shift_seq;

    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic          ready, busy, done;
    logic [W-1:0]  dout;

    shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .amt   (amt),
        .din   (din),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           n;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: whole-amount shift/rotate done with wide arithmetic.
    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input int n, input logic [W-1:0] d);
        logic [31:0] x;
        logic [31:0] r;
        x = {16'h0, d};
        case (o)
            2'b00:   r = x << n;
            2'b01:   r = x >> n;
            2'b10:   r = (x << n) | (x >> (W - n));
            default: r = (x >> n) | (x << (W - n));
        endcase
        return r[W-1:0];
    endfunction

    // Acceptance model: a job accepted at edge A with n steps finishes at
    // edge A+n, and the next acceptance is possible at edge A+n+2.
    int next_accept = 0;
    bit obs_armed   = 0;
    always @(negedge clk) begin
        if (obs_armed)
            check("ready", {31'h0, ready}, {31'h0, (cyc + 1 >= next_accept)});
        if (reset) begin
            next_accept = cyc + 2;
            obs_armed   = 1;
        end else if (obs_armed && start && (cyc + 1 >= next_accept)) begin
            q.push_back('{res: ref_op(op, int'(amt), din), acc: cyc + 1, n: int'(amt)});
            next_accept = cyc + 1 + int'(amt) + 2;
        end
    end

    // Monitor: compares on done, checks hold value and post-reset outputs.
    logic [W-1:0] last_res = '0;
    bit           mon_armed = 0;
    bit           rst_prev  = 0;
    exp_t         e;
    always @(negedge clk) begin
        if (mon_armed) begin
            check("onehot", {29'h0, ready, busy, done},
                  {29'h0, 3'(1 << ((ready ? 2 : 0) + (busy ? 1 : 0) + (done ? 0 : 0)))} & 32'h0
                  | {29'h0, ready, busy, done});
            check("exclusive", 32'(int'(ready) + int'(busy) + int'(done)), 32'd1);
            if (rst_prev) begin
                check("rst_ready", {31'h0, ready}, 32'd1);
                check("rst_busy",  {31'h0, busy},  32'd0);
                check("rst_done",  {31'h0, done},  32'd0);
                check("rst_dout",  {16'h0, dout},  32'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("result",  {16'h0, dout}, {16'h0, e.res});
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.n + 1));
                    last_res = e.res;
                end
            end else if (ready && !rst_prev) begin
                check("hold", {16'h0, dout}, {16'h0, last_res});
            end
        end
        if (reset) begin
            q.delete();
            last_res  = '0;
            mon_armed = 1;
            rst_prev  = 1;
        end else begin
            rst_prev = 0;
        end
    end

    task automatic scramble();
        op  = 2'($urandom);
        amt = AW'($urandom);
        din = W'($urandom);
    endtask

    task automatic pulse(input logic [1:0] o, input logic [AW-1:0] n, input logic [W-1:0] d);
        @(posedge clk); #1;
        start = 1'b1; op = o; amt = n; din = d;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        repeat (int'(n) + 1) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; amt = '0; din = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Known vectors
        pulse(2'b00, 4'd4,  16'h0001);
        pulse(2'b11, 4'd1,  16'h8001);
        pulse(2'b10, 4'd8,  16'h55AA);
        pulse(2'b01, 4'd15, 16'hFFFF);
        pulse(2'b00, 4'd0,  16'h7FFF);

        // Second start during RUN is ignored
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; amt = 4'd3; din = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; amt = 4'd5; din = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);

        // Reset on the third RUN edge of a long job
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; amt = 4'd10; din = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // start held continuously with changing operands
        @(posedge clk); #1;
        start = 1'b1;
        repeat (80) begin
            scramble();
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        // Random traffic with occasional resets
        repeat (600) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 60) == 0);
            scramble();
        end
        #0;
        start = 1'b0;
        reset = 1'b0;

        // Drain with a bounded wait
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter AMT_W, default 4, shift-amount width; maximum amount is 2**AMT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only on a rising edge where ready=1.
REQ-006 op  input  2  operation: 00 logical shift left, 01 logical shift right, 10 rotate left, 11 rotate right.
REQ-007 amt  input  AMT_W  number of 1-bit steps to apply.
REQ-008 din  input  WIDTH  operand.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 busy  output  1  high in RUN only.
REQ-011 done  output  1  one-cycle pulse, high in DONE only.
REQ-012 dout  output  WIDTH  result register.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 On accepted start, block SHALL latch op, din into the working register, and amt into a down-counter.
REQ-015 Accepted start with amt=0 SHALL go IDLE->DONE; with amt>0, IDLE->RUN.
REQ-016 Each RUN edge SHALL apply exactly one 1-bit step of the latched op to the working register and decrement the counter.
REQ-017 RUN edge where counter goes 1->0 SHALL transition to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 done SHALL be high in the cycle after the amt-th RUN edge, i.e. amt+1 edges after acceptance (1 edge for amt=0).
REQ-020 Logical shifts SHALL fill the vacated bit with 0; rotates SHALL move the bit shifted out into the vacated bit.
REQ-021 dout SHALL equal the working register and SHALL hold its final value from DONE until the next accepted start.
REQ-022 start while RUN or DONE SHALL be ignored; op/amt/din changes after acceptance SHALL not affect the result.
REQ-023 start on the DONE->IDLE edge SHALL be ignored; the earliest new acceptance is the following edge.

Reset
REQ-024 reset high at an edge SHALL force IDLE, counter=0, dout=0, regardless of state (including mid-RUN) and of start.
REQ-025 After reset: ready=1, busy=0, done=0, dout=0; an aborted operation SHALL produce no done pulse.

Structure
REQ-026 A shared package shift_pkg SHALL hold the op encodings, WIDTH/AMT_W defaults and the FSM state type.
REQ-027 The single-bit step SHALL be a combinational sub-module shift_step (op, WIDTH-bit in, WIDTH-bit out) instantiated once.
REQ-028 Counter, FSM and working register SHALL live in shift_seq; no combinational path from start to done.

Verification
REQ-029 op=00, din=0x0001, amt=4 -> done 5 edges after acceptance, dout=0x0010.
REQ-030 op=11, din=0x8001, amt=1 -> done 2 edges after acceptance, dout=0xC000; op=10, din=0x55AA, amt=8 -> dout=0xAA55.
REQ-031 op=01, din=0xFFFF, amt=15 -> done 16 edges after, dout=0x0001; op=00, din=0x7FFF, amt=0 -> done after 1 edge, dout=0x7FFF.
REQ-032 Second start (din=0x1234) pulsed during RUN of op=10, din=0x0001, amt=3 -> ignored, dout=0x0008, single done pulse.
REQ-033 reset asserted on 3rd RUN edge of amt=10 job -> next cycle ready=1, busy=0, dout=0x0000, no done pulse.
REQ-034 Back-to-back: start held high continuously -> jobs accepted only in IDLE, one done per job, ready never high simultaneously with busy or done.
